// File: rtl/bb_pkg.sv
// Shared types and constants for the baseball play driver: action codes,
// driver FSM states, the scorer-facing play payload and scoring helpers.
package bb_pkg;

    localparam logic [2:0] ACT_WALK   = 3'd0;
    localparam logic [2:0] ACT_SINGLE = 3'd1;
    localparam logic [2:0] ACT_DOUBLE = 3'd2;
    localparam logic [2:0] ACT_TRIPLE = 3'd3;
    localparam logic [2:0] ACT_HR     = 3'd4;
    localparam logic [2:0] ACT_BUNT   = 3'd5;
    localparam logic [2:0] ACT_GROUND = 3'd6;
    localparam logic [2:0] ACT_FLY    = 3'd7;

    localparam logic [1:0] LAST_INNING = 2'd3;

    typedef enum logic [2:0] {IDLE, FILL, PLAY, WAIT_RES, DONE} state_e;

    typedef struct packed {
        logic [1:0] inning;
        logic       half;
        logic [2:0] action;
    } bb_play_t;

    // Outs charged to the batting team; a grounder with a runner on 1st is a double play.
    function automatic logic [1:0] outs_added(input logic [2:0] act, input logic on_first);
        logic [1:0] n;
        n = 2'd0;
        case (act)
            ACT_BUNT, ACT_FLY: n = 2'd1;
            ACT_GROUND:        n = on_first ? 2'd2 : 2'd1;
            default:           n = 2'd0;
        endcase
        return n;
    endfunction

    // Runs crossing the plate for one action, given outs and bases before it.
    function automatic logic [2:0] runs_scored(input logic [2:0] act, input logic [1:0] outs,
                                               input logic [2:0] b);
        logic [2:0] on_base;
        logic [2:0] r;
        on_base = 3'(b[0]) + 3'(b[1]) + 3'(b[2]);
        r       = 3'd0;
        case (act)
            ACT_WALK:             r = 3'(&b);
            ACT_SINGLE:           r = (outs == 2'd2) ? 3'(b[1]) + 3'(b[2]) : 3'(b[2]);
            ACT_DOUBLE:           r = (outs == 2'd2) ? on_base : 3'(b[1]) + 3'(b[2]);
            ACT_TRIPLE:           r = on_base;
            ACT_HR:               r = on_base + 3'd1;
            ACT_BUNT, ACT_GROUND: r = 3'(b[2]);
            ACT_FLY:              r = (outs < 2'd2) ? 3'(b[2]) : 3'd0;
            default:              r = 3'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bb_play_driver_if.sv
// Bundle of the upstream action channel, the scorer channel and the result outputs.
interface bb_play_driver_if;
    logic       start;
    logic       act_valid;
    logic       act_ready;
    logic [2:0] act;
    logic       bb_in_valid;
    logic [1:0] bb_inning;
    logic       bb_half;
    logic [2:0] bb_action;
    logic       bb_out_valid;
    logic [7:0] bb_score_A;
    logic [7:0] bb_score_B;
    logic [1:0] bb_result;
    logic [7:0] final_A;
    logic [7:0] final_B;
    logic [1:0] final_result;
    logic       game_done;
    logic       underrun;

    modport master (
        input  start, act_valid, act, bb_out_valid, bb_score_A, bb_score_B, bb_result,
        output act_ready, bb_in_valid, bb_inning, bb_half, bb_action,
               final_A, final_B, final_result, game_done, underrun
    );

    modport slave (
        output start, act_valid, act, bb_out_valid, bb_score_A, bb_score_B, bb_result,
        input  act_ready, bb_in_valid, bb_inning, bb_half, bb_action,
               final_A, final_B, final_result, game_done, underrun
    );
endinterface

// File: rtl/bb_act_fifo.sv
// Synchronous DEPTH x 3-bit action FIFO with flush, occupancy count, full and empty.
module bb_act_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [2:0]                 wdata_i,
    input  logic                       pop_i,
    output logic [2:0]                 rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok, pop_ok;

    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o && !flush_i;
    assign push_ok = push_i && (!full_o || pop_ok) && !flush_i;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/bb_play_driver.sv
// Buffers upstream play actions and bursts them to the scorer with inning/half stamps,
// then latches the scorer's finals. Optional BB_SKIP_BOTTOM3_EN ends the game after
// top 3 when team B already leads.
module bb_play_driver
    import bb_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned START_LVL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    bb_play_driver_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_e     state_q, state_d;
    logic [1:0] inning_q, inning_d, outs_q, outs_d;
    logic       half_q, half_d;
    logic [2:0] bases_q, bases_d, bases_nx;
    bb_play_t   play_q, play_d;
    logic       in_valid_q, in_valid_d;
    logic [7:0] final_a_q, final_a_d, final_b_q, final_b_d;
    logic [1:0] final_res_q, final_res_d;
    logic       game_done_q, game_done_d, underrun_q, underrun_d;
`ifdef BB_SKIP_BOTTOM3_EN
    logic [7:0] runs_a_q, runs_a_d, runs_b_q, runs_b_d;
    logic [2:0] runs_nx;
`endif

    logic          flush_c, push_c, pop_c, act_ready_c;
    logic          fifo_full, fifo_empty;
    logic [2:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic [2:0]    outs_sum;
    logic          half_end, game_end;

    assign act_ready_c = ((state_q == FILL) || (state_q == PLAY)) && !fifo_full;
    assign push_c      = bus.act_valid && act_ready_c;
    assign pop_c       = (state_q == PLAY) && !fifo_empty;

    bb_act_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_c),
        .push_i  (push_c),
        .wdata_i (bus.act),
        .pop_i   (pop_c),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign outs_sum = 3'(outs_q) + 3'(outs_added(fifo_rdata, bases_q[0]));
    assign half_end = (outs_sum >= 3'd3);
`ifdef BB_SKIP_BOTTOM3_EN
    assign runs_nx  = runs_scored(fifo_rdata, outs_q, bases_q);
    assign game_end = half_end && (inning_q == LAST_INNING) && (half_q || (runs_b_q > runs_a_q));
`else
    assign game_end = half_end && (inning_q == LAST_INNING) && half_q;
`endif

    // Base occupancy after the action at the FIFO head (b[0]=1st .. b[2]=3rd).
    always_comb begin
        bases_nx = bases_q;
        case (fifo_rdata)
            ACT_WALK:   bases_nx = {bases_q[2] | (&bases_q[1:0]), bases_q[1] | bases_q[0], 1'b1};
            ACT_SINGLE: bases_nx = (outs_q == 2'd2) ? {bases_q[0], 2'b01} : {bases_q[1:0], 1'b1};
            ACT_DOUBLE: bases_nx = (outs_q == 2'd2) ? 3'b010 : {bases_q[0], 2'b10};
            ACT_TRIPLE: bases_nx = 3'b100;
            ACT_HR:     bases_nx = 3'b000;
            ACT_BUNT:   bases_nx = {bases_q[1:0], 1'b0};
            ACT_GROUND: bases_nx = {bases_q[1], 2'b00};
            ACT_FLY:    bases_nx = (outs_q < 2'd2) ? {1'b0, bases_q[1:0]} : bases_q;
            default:    bases_nx = bases_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        inning_d    = inning_q;
        half_d      = half_q;
        outs_d      = outs_q;
        bases_d     = bases_q;
        play_d      = play_q;
        in_valid_d  = 1'b0;
        final_a_d   = final_a_q;
        final_b_d   = final_b_q;
        final_res_d = final_res_q;
        game_done_d = 1'b0;
        underrun_d  = underrun_q;
        flush_c     = 1'b0;
`ifdef BB_SKIP_BOTTOM3_EN
        runs_a_d    = runs_a_q;
        runs_b_d    = runs_b_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = FILL;
                    inning_d   = 2'd1;
                    half_d     = 1'b0;
                    outs_d     = 2'd0;
                    bases_d    = 3'b000;
                    underrun_d = 1'b0;
                    flush_c    = 1'b1;
`ifdef BB_SKIP_BOTTOM3_EN
                    runs_a_d   = 8'd0;
                    runs_b_d   = 8'd0;
`endif
                end
            end
            FILL: begin
                if (fifo_count >= CW'(START_LVL)) state_d = PLAY;
            end
            PLAY: begin
                if (fifo_empty) begin
                    underrun_d = 1'b1;
                    state_d    = WAIT_RES;
                end else begin
                    in_valid_d = 1'b1;
                    play_d     = '{inning: inning_q, half: half_q, action: fifo_rdata};
                    if (half_end) begin
                        // Runs on the inning-ending out never count.
                        outs_d  = 2'd0;
                        bases_d = 3'b000;
                        half_d  = ~half_q;
                        if (half_q) inning_d = inning_q + 2'd1;
                        if (game_end) begin
                            state_d = WAIT_RES;
                            flush_c = 1'b1;
                        end
                    end else begin
                        outs_d  = outs_sum[1:0];
                        bases_d = bases_nx;
`ifdef BB_SKIP_BOTTOM3_EN
                        if (half_q) runs_b_d = runs_b_q + 8'(runs_nx);
                        else        runs_a_d = runs_a_q + 8'(runs_nx);
`endif
                    end
                end
            end
            WAIT_RES: begin
                if (bus.bb_out_valid) begin
                    final_a_d   = bus.bb_score_A;
                    final_b_d   = bus.bb_score_B;
                    final_res_d = bus.bb_result;
                    game_done_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            inning_q    <= 2'd1;
            half_q      <= 1'b0;
            outs_q      <= 2'd0;
            bases_q     <= 3'b000;
            play_q      <= '0;
            in_valid_q  <= 1'b0;
            final_a_q   <= 8'd0;
            final_b_q   <= 8'd0;
            final_res_q <= 2'd0;
            game_done_q <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef BB_SKIP_BOTTOM3_EN
            runs_a_q    <= 8'd0;
            runs_b_q    <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            inning_q    <= inning_d;
            half_q      <= half_d;
            outs_q      <= outs_d;
            bases_q     <= bases_d;
            play_q      <= play_d;
            in_valid_q  <= in_valid_d;
            final_a_q   <= final_a_d;
            final_b_q   <= final_b_d;
            final_res_q <= final_res_d;
            game_done_q <= game_done_d;
            underrun_q  <= underrun_d;
`ifdef BB_SKIP_BOTTOM3_EN
            runs_a_q    <= runs_a_d;
            runs_b_q    <= runs_b_d;
`endif
        end
    end

    assign bus.act_ready    = act_ready_c;
    assign bus.bb_in_valid  = in_valid_q;
    assign bus.bb_inning    = play_q.inning;
    assign bus.bb_half      = play_q.half;
    assign bus.bb_action    = play_q.action;
    assign bus.final_A      = final_a_q;
    assign bus.final_B      = final_b_q;
    assign bus.final_result = final_res_q;
    assign bus.game_done    = game_done_q;
    assign bus.underrun     = underrun_q;
endmodule

// File: doc/bb_play_driver.md
# bb_play_driver

Transmit-side companion to the baseball scorer: buffers an upstream stream of 3-bit play actions and drives them to the scorer as one contiguous burst (`in_valid`, `inning`, `half`, `action`). Tracks outs and base occupancy itself to stamp the correct inning and half on every action, and stops the burst at the end of the game. Then waits for the scorer's `out_valid` and latches the final scores and result for the testbench or controller above it.

## Interface
- `DEPTH`, 8: action FIFO depth; power of two, at least 4.
- `START_LVL`, 4: FIFO occupancy required before the burst starts; 1 ≤ `START_LVL` ≤ `DEPTH`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  single-cycle game start; honoured only in IDLE.
- `act_valid`  in  1  upstream action valid.
- `act_ready`  out  1  FIFO can accept; high only in FILL/PLAY and not full.
- `act`  in  3  action code: 0 walk, 1 single, 2 double, 3 triple, 4 HR, 5 bunt, 6 ground, 7 fly.
- `bb_in_valid`  out  1  action valid to scorer.
- `bb_inning`  out  2  inning 1..3.
- `bb_half`  out  1  0 top (team A bats), 1 bottom (team B bats).
- `bb_action`  out  3  action code.
- `bb_out_valid`  in  1  scorer result valid.
- `bb_score_A`  in  8  scorer score, team A.
- `bb_score_B`  in  8  scorer score, team B.
- `bb_result`  in  2  scorer result.
- `final_A`  out  8  latched score, team A.
- `final_B`  out  8  latched score, team B.
- `final_result`  out  2  latched result.
- `game_done`  out  1  one-cycle pulse when the finals are valid.
- `underrun`  out  1  sticky: FIFO ran empty mid-game; cleared on `start`.

## Operation
- States and transitions:
  - IDLE → FILL on `start`. Entering FILL flushes the FIFO, sets inning=1, half=0, outs=0, bases=000, runs=0, and clears `underrun`.
  - FILL → PLAY when count ≥ `START_LVL`.
  - PLAY pops one action every cycle.
  - PLAY → WAIT_RES at end of game, or on underrun (FIFO empty in PLAY: set `underrun`).
  - WAIT_RES → DONE on `bb_out_valid`: latch `final_*` from the `bb_*` inputs.
  - DONE → IDLE after one cycle, pulsing `game_done`.
- Outs added per action:
  - bunt: +1.
  - ground: +2 if a runner is on 1st, else +1.
  - fly: +1.
  - all other actions: +0.
- Half-inning end: outs ≥ 3 (2 outs plus a double play counts). Then outs=0 and bases=000, and half toggles; inning increments on a bottom→top change.
- Base update (`b[0]`=1st, `b[1]`=2nd, `b[2]`=3rd; outs = value before the action):
  - walk: forced advance only.
  - single: with 2 outs, runners advance 2; else 1. Batter to 1st.
  - double: with 2 outs, all runners score; else the runner from 1st goes to 3rd. Batter to 2nd.
  - triple/HR: all runners score. Batter to 3rd, or scores on HR.
  - bunt: all runners advance 1.
  - ground: 3rd scores, 2nd→3rd, 1st cleared.
  - fly: with <2 outs, the runner on 3rd scores; otherwise no change.
  - Runs scored on the out that ends the half are not counted.
- End of game: the half ends with inning=3, half=1. The last emitted action is the one that caused it.
- Remaining FIFO entries after end of game are discarded.

## Timing
- Reset values:
  - all outputs 0; state IDLE.
  - internal: inning=1, half=0, outs=0, bases=000, runs=0.
- `bb_*` outputs are registered. An action popped in cycle t appears in cycle t+1 with the inning/half in force before that action.
- `bb_in_valid` is continuous from the first to the last action. It falls the cycle after the final action; the scorer detects end of game on that edge.
- Simultaneous push and pop with the FIFO full is allowed; `act_ready` is computed from the pre-pop count.
- `start` outside IDLE is ignored.
- Reset mid-PLAY: `bb_in_valid` drops immediately (asynchronous), returns to IDLE.

## Configuration
- `BB_SKIP_BOTTOM3_EN` defined:
  - the driver keeps 8-bit run counters per team;
  - at the end of top 3, if runs_B > runs_A, the game ends there and bottom 3 is never emitted.
- Not defined: no run counters; bottom 3 is always played.

## Structure
- Shared package `bb_pkg` holds:
  - action code constants (`ACT_WALK`..`ACT_FLY`);
  - state enum (IDLE, FILL, PLAY, WAIT_RES, DONE);
  - `LAST_INNING`=3.
- Sub-module `bb_act_fifo`: synchronous FIFO of `DEPTH`×3 bits, with flush, count, full and empty.

## Test plan
- `start`, then 18 fly balls streamed:
  - 18 contiguous `bb_in_valid` cycles; half toggles every 3 actions, inning 1,1,1,1,1,1,2…3;
  - scorer returns 0-0 → `final_result`=2, `game_done` pulse.
- Top 1 sequence walk, ground, fly:
  - ground adds 2 outs (runner on 1st);
  - the 4th action carries `bb_half`=1, `bb_inning`=1.
- Feed 5 actions then hold `act_valid`=0:
  - after 5 emitted actions, `bb_in_valid` falls and `underrun`=1;
  - `final_*` is latched on `bb_out_valid`.
- `BB_SKIP_BOTTOM3_EN`: fly×3, HR + fly×3 in bottom 1, then fly×9:
  - burst ends after 16 actions; `final_B`=1, `final_A`=0, `final_result`=1.
  - Without the macro: 19 actions.
- Upstream pushes 8 actions while `START_LVL`=8 → `act_ready`=0 at count 8, PLAY starts the next cycle.
- Assert `rst_n`=0 during PLAY → all outputs 0 immediately; the next `start` replays from inning 1, top.
